// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 operand multiplexer with valid/ready on every channel.
// Explicit-select (MODE=0) or round-robin (MODE=1) choice of the producer.
module mux_nto1_reg #(
    parameter int W     = 64,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N),
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [N*W-1:0]     in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [W-1:0]       out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   xfer_cnt
);

    localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

    logic [W-1:0]     out_data_r;
    logic [SEL_W-1:0] out_src_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] xfer_cnt_r;
    logic [SEL_W-1:0] rr_ptr_r;

    logic             load_en_s;
    logic             cand_ok_s;
    logic             cand_vld_s;
    logic [SEL_W-1:0] cand_idx_s;
    logic [W-1:0]     cand_data_s;
    logic             grant_s;
    logic [N-1:0]     rot_s;
    logic [SEL_W-1:0] offset_s;
    logic [SEL_W:0]   sum_s;
    logic [N-1:0]     in_ready_s;

    // Candidate selection, grant decision and per-channel ready.
    always_comb begin
        load_en_s   = !out_valid_r || out_ready;
        cand_ok_s   = 1'b0;
        cand_vld_s  = 1'b0;
        cand_idx_s  = '0;
        cand_data_s = '0;
        rot_s       = '0;
        offset_s    = '0;
        sum_s       = '0;
        in_ready_s  = '0;
        if (MODE == 0) begin
            cand_idx_s = sel;
            for (int i = 0; i < N; i++) begin
                if (sel == SEL_W'(i)) begin
                    cand_ok_s  = 1'b1;
                    cand_vld_s = in_valid[i];
                end else begin
                    cand_ok_s  = cand_ok_s;
                end
            end
        end else begin
            // Rotate so bit 0 is the channel at rr_ptr; lowest set bit wins.
            rot_s = N'({in_valid, in_valid} >> rr_ptr_r);
            for (int k = N - 1; k >= 0; k--) begin
                if (rot_s[k]) begin
                    offset_s = SEL_W'(k);
                end else begin
                    offset_s = offset_s;
                end
            end
            sum_s = {1'b0, rr_ptr_r} + {1'b0, offset_s};
            if (sum_s >= N_L) begin
                sum_s = sum_s - N_L;
            end else begin
                sum_s = sum_s;
            end
            cand_idx_s = sum_s[SEL_W-1:0];
            cand_ok_s  = |in_valid;
            cand_vld_s = |in_valid;
        end
        for (int i = 0; i < N; i++) begin
            if (cand_idx_s == SEL_W'(i)) begin
                cand_data_s   = in_data[i*W +: W];
                in_ready_s[i] = load_en_s && cand_ok_s;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
        grant_s = load_en_s && cand_ok_s && cand_vld_s;
    end

    // Output register, transfer counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_data_r  <= '0;
            out_src_r   <= '0;
            out_valid_r <= 1'b0;
            xfer_cnt_r  <= '0;
            rr_ptr_r    <= '0;
        end else begin
            if (grant_s) begin
                out_data_r  <= cand_data_s;
                out_src_r   <= cand_idx_s;
                out_valid_r <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (out_valid_r && out_ready) begin
                xfer_cnt_r <= xfer_cnt_r + CNT_W'(1);
            end
            if ((MODE != 0) && grant_s) begin
                if (cand_idx_s == SEL_W'(N - 1)) begin
                    rr_ptr_r <= '0;
                end else begin
                    rr_ptr_r <= cand_idx_s + SEL_W'(1);
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign out_valid = out_valid_r;
    assign xfer_cnt  = xfer_cnt_r;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed bench for mux_nto1_reg: explicit-select, round-robin and
// narrow-counter instances share one clock and reset.
module tb_mux_nto1_reg;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // explicit select, SEL_W=3 so an out-of-range select can be driven
    logic [255:0] d0;
    logic [3:0]   v0, r0;
    logic [2:0]   s0, os0;
    logic [63:0]  od0;
    logic         ov0, ordy0;
    logic [15:0]  cnt0;

    // round robin
    logic [255:0] d1;
    logic [3:0]   v1, r1;
    logic [1:0]   s1, os1;
    logic [63:0]  od1;
    logic         ov1, ordy1;
    logic [15:0]  cnt1;

    // 8-bit data, 4-bit counter
    logic [31:0]  d8;
    logic [3:0]   v8, r8;
    logic [1:0]   s8, os8;
    logic [7:0]   od8;
    logic         ov8, ordy8;
    logic [3:0]   cnt8;

    mux_nto1_reg #(.W(64), .N(4), .SEL_W(3), .MODE(0), .CNT_W(16)) u_m0 (
        .clk(clk), .rst_b(rst_b), .in_data(d0), .in_valid(v0), .in_ready(r0),
        .sel(s0), .out_data(od0), .out_src(os0), .out_valid(ov0),
        .out_ready(ordy0), .xfer_cnt(cnt0));

    mux_nto1_reg #(.W(64), .N(4), .SEL_W(2), .MODE(1), .CNT_W(16)) u_m1 (
        .clk(clk), .rst_b(rst_b), .in_data(d1), .in_valid(v1), .in_ready(r1),
        .sel(s1), .out_data(od1), .out_src(os1), .out_valid(ov1),
        .out_ready(ordy1), .xfer_cnt(cnt1));

    mux_nto1_reg #(.W(8), .N(4), .SEL_W(2), .MODE(0), .CNT_W(4)) u_n8 (
        .clk(clk), .rst_b(rst_b), .in_data(d8), .in_valid(v8), .in_ready(r8),
        .sel(s8), .out_data(od8), .out_src(os8), .out_valid(ov8),
        .out_ready(ordy8), .xfer_cnt(cnt8));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0]      sh8;
    logic [7:0]       exp_d8;
    logic [1:0]       exp_s8;
    logic [1:0]       rr_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        rst_b = 1'b0;
        d0 = '0; v0 = '0; s0 = '0; ordy0 = 1'b0;
        d1 = '0; v1 = '0; s1 = '0; ordy1 = 1'b0;
        d8 = '0; v8 = '0; s8 = '0; ordy8 = 1'b0;
        #2;
        check_eq("rst_m0_valid", {63'd0, ov0}, 64'd0);
        check_eq("rst_m0_data", od0, 64'd0);
        check_eq("rst_m0_cnt", {48'd0, cnt0}, 64'd0);
        check_eq("rst_m1_valid", {63'd0, ov1}, 64'd0);
        check_eq("rst_n8_cnt", {60'd0, cnt8}, 64'd0);
        #10 rst_b = 1'b1;
        tick();

        // explicit select of channel 2
        s0 = 3'd2; v0 = 4'hF; ordy0 = 1'b1;
        d0 = {64'h0000_0000_0000_DDDD, 64'hFFFF_FFFF_FFFF_FF80,
              64'h0000_0000_0000_BBBB, 64'h0000_0000_0000_AAAA};
        #1 check_eq("m0_ready_sel2", {60'd0, r0}, 64'h4);
        tick();
        check_eq("m0_data", od0, 64'hFFFF_FFFF_FFFF_FF80);
        check_eq("m0_src", {61'd0, os0}, 64'd2);
        check_eq("m0_valid", {63'd0, ov0}, 64'd1);
        check_eq("m0_cnt0", {48'd0, cnt0}, 64'd0);
        tick();
        check_eq("m0_cnt1", {48'd0, cnt0}, 64'd1);
        tick();
        check_eq("m0_cnt2", {48'd0, cnt0}, 64'd2);

        // out-of-range select: no candidate, held word drains
        s0 = 3'd5;
        #1 check_eq("m0_ready_sel5", {60'd0, r0}, 64'd0);
        tick();
        check_eq("m0_drain_valid", {63'd0, ov0}, 64'd0);
        check_eq("m0_drain_cnt", {48'd0, cnt0}, 64'd3);
        check_eq("m0_drain_data", od0, 64'hFFFF_FFFF_FFFF_FF80);
        tick();
        check_eq("m0_idle_valid", {63'd0, ov0}, 64'd0);
        check_eq("m0_idle_cnt", {48'd0, cnt0}, 64'd3);

        // backpressure on a word from channel 1
        s0 = 3'd1; v0 = 4'b0010; d0[64 +: 64] = 64'd42;
        #1 check_eq("m0_ready_sel1", {60'd0, r0}, 64'h2);
        tick();
        check_eq("bp_load_data", od0, 64'd42);
        check_eq("bp_load_src", {61'd0, os0}, 64'd1);
        ordy0 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            s0 = 3'($urandom_range(0, 7));
            v0 = 4'($urandom);
            for (int j = 0; j < 4; j++) d0[j*64 +: 64] = {$urandom, $urandom};
            #1 check_eq("bp_ready", {60'd0, r0}, 64'd0);
            tick();
            check_eq("bp_data", od0, 64'd42);
            check_eq("bp_src", {61'd0, os0}, 64'd1);
            check_eq("bp_valid", {63'd0, ov0}, 64'd1);
            check_eq("bp_cnt", {48'd0, cnt0}, 64'd3);
        end
        ordy0 = 1'b1; v0 = 4'd0;
        tick();
        check_eq("bp_release_valid", {63'd0, ov0}, 64'd0);
        check_eq("bp_release_cnt", {48'd0, cnt0}, 64'd4);
        ordy0 = 1'b0;

        // round robin with all channels valid
        for (int j = 0; j < 4; j++) d1[j*64 +: 64] = 64'h100 + 64'(j);
        v1 = 4'hF; ordy1 = 1'b1;
        #1 check_eq("rr_ready_first", {60'd0, r1}, 64'h1);
        for (int c = 0; c < 6; c++) begin
            tick();
            check_eq("rr_src", {62'd0, os1}, {62'd0, rr_exp[c]});
            check_eq("rr_data", od1, 64'h100 + {62'd0, rr_exp[c]});
            check_eq("rr_cnt", {48'd0, cnt1}, 64'(c));
        end
        v1 = 4'b1010;
        #1 check_eq("rr_ready_ptr2", {60'd0, r1}, 64'h8);
        tick();
        check_eq("rr_src_3", {62'd0, os1}, 64'd3);
        check_eq("rr_data_3", od1, 64'h103);
        check_eq("rr_cnt_6", {48'd0, cnt1}, 64'd6);
        check_eq("rr_ready_wrap", {60'd0, r1}, 64'h2);
        tick();
        check_eq("rr_src_1", {62'd0, os1}, 64'd1);
        check_eq("rr_cnt_7", {48'd0, cnt1}, 64'd7);
        v1 = 4'b0100;
        tick();
        check_eq("rr_src_2", {62'd0, os1}, 64'd2);

        // asynchronous reset between edges, pointer now 3
        #2 rst_b = 1'b0;
        #1;
        check_eq("arst_valid", {63'd0, ov1}, 64'd0);
        check_eq("arst_data", od1, 64'd0);
        check_eq("arst_src", {62'd0, os1}, 64'd0);
        check_eq("arst_cnt", {48'd0, cnt1}, 64'd0);
        v1 = 4'hF;
        #1 rst_b = 1'b1;
        #1 check_eq("arst_ready", {60'd0, r1}, 64'h1);
        tick();
        check_eq("arst_first_src", {62'd0, os1}, 64'd0);
        check_eq("arst_first_data", od1, 64'h100);
        check_eq("arst_first_valid", {63'd0, ov1}, 64'd1);
        v1 = 4'd0;

        // 8-bit random run against a model, 17 transfers on a 4-bit counter
        ordy8 = 1'b1; v8 = 4'hF;
        for (int c = 0; c < 17; c++) begin
            s8 = 2'($urandom_range(0, 3));
            for (int j = 0; j < 4; j++) d8[j*8 +: 8] = 8'($urandom);
            sh8 = d8 >> ({3'd0, s8} * 5'd8);
            exp_d8 = sh8[7:0];
            exp_s8 = s8;
            tick();
            check_eq("n8_data", {56'd0, od8}, {56'd0, exp_d8});
            check_eq("n8_src", {62'd0, os8}, {62'd0, exp_s8});
            check_eq("n8_valid", {63'd0, ov8}, 64'd1);
            if (c == 16) check_eq("n8_cnt_wrap0", {60'd0, cnt8}, 64'd0);
        end
        v8 = 4'd0;
        tick();
        check_eq("n8_cnt_17", {60'd0, cnt8}, 64'd1);
        check_eq("n8_drain_valid", {63'd0, ov8}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
